// File: rtl/regfile_mp_sb_if.sv
// Register-file bus between decode/writeback (master) and regfile_mp_sb (slave).
// Carries two read ports, two write ports, the destination-reservation port and
// the live scoreboard vector; clk/reset are passed to the register file separately.
interface regfile_mp_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   localparam int DEPTH = 2**ADDR_W;

   // read ports
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_busy_a;
   logic              rd_busy_b;

   // write ports (port 1 carries the younger instruction)
   logic              wr_en_0;
   logic [ADDR_W-1:0] wr_addr_0;
   logic [DATA_W-1:0] wr_data_0;
   logic              wr_en_1;
   logic [ADDR_W-1:0] wr_addr_1;
   logic [DATA_W-1:0] wr_data_1;

   // destination reservation and scoreboard
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      output rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
      output wr_en_0, wr_addr_0, wr_data_0,
      output wr_en_1, wr_addr_1, wr_data_1,
      output rsv_en, rsv_addr,
      input  busy_vec
   );

   modport slave (
      input  rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
      input  wr_en_0, wr_addr_0, wr_data_0,
      input  wr_en_1, wr_addr_1, wr_data_1,
      input  rsv_en, rsv_addr,
      output busy_vec
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// Register file, 2 registered read ports / 2 write ports, with per-register busy scoreboard.
// Ports: clk, reset (async active-high), bus (regfile_mp_sb_if.slave) carrying reads,
// writes, reservation and busy_vec. Read latency 1 cycle, write-first; no backpressure.
module regfile_mp_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic           clk,
   input  logic           reset,
   regfile_mp_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs      [DEPTH];
   logic [DATA_W-1:0] regs_next [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;

   logic wr_ok_0;
   logic wr_ok_1;
   logic rsv_ok;

   // With a hard-wired zero register, anything aimed at r0 is dropped here so
   // r0 stays at its reset value (0) and is never marked busy.
   always_comb begin
      wr_ok_0 = bus.wr_en_0;
      wr_ok_1 = bus.wr_en_1;
      rsv_ok  = bus.rsv_en;
      if (ZERO_REG != 0) begin
         if (bus.wr_addr_0 == '0) wr_ok_0 = 1'b0;
         if (bus.wr_addr_1 == '0) wr_ok_1 = 1'b0;
         if (bus.rsv_addr  == '0) rsv_ok  = 1'b0;
      end
   end

   // Next-state of the whole file. Order of the ifs sets priority:
   // port 1 overrides port 0 on the same address (younger instruction wins),
   // and a reservation overrides a release (a new producer is in flight).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_next[i] = regs[i];
         busy_next[i] = busy[i];
         if (wr_ok_0 && (bus.wr_addr_0 == ADDR_W'(i))) begin
            regs_next[i] = bus.wr_data_0;
            busy_next[i] = 1'b0;
         end
         if (wr_ok_1 && (bus.wr_addr_1 == ADDR_W'(i))) begin
            regs_next[i] = bus.wr_data_1;
            busy_next[i] = 1'b0;
         end
         if (rsv_ok && (bus.rsv_addr == ADDR_W'(i))) begin
            busy_next[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= regs_next[i];
         end
         busy <= busy_next;
      end
   end

   // Reads sample the next-state arrays, which gives write-first bypass for
   // data and keeps rd_busy_x consistent with the data returned alongside it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rd_data_a <= '0;
         bus.rd_data_b <= '0;
         bus.rd_busy_a <= 1'b0;
         bus.rd_busy_b <= 1'b0;
      end else begin
         bus.rd_data_a <= regs_next[bus.rd_addr_a];
         bus.rd_data_b <= regs_next[bus.rd_addr_b];
         bus.rd_busy_a <= busy_next[bus.rd_addr_a];
         bus.rd_busy_b <= busy_next[bus.rd_addr_b];
      end
   end

   // Scoreboard output comes straight from flops: no input-to-output path.
   assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3)) if_a ();
   regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3)) if_z ();
   regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5)) if_w ();

   regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_rf (.clk(clk), .reset(reset), .bus(if_a.slave));
   regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_zr (.clk(clk), .reset(reset), .bus(if_z.slave));
   regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_wd (.clk(clk), .reset(reset), .bus(if_w.slave));

   // the ZERO_REG=1 instance sees exactly the same stimulus as u_rf
   assign if_z.rd_addr_a = if_a.rd_addr_a;
   assign if_z.rd_addr_b = if_a.rd_addr_b;
   assign if_z.wr_en_0   = if_a.wr_en_0;
   assign if_z.wr_addr_0 = if_a.wr_addr_0;
   assign if_z.wr_data_0 = if_a.wr_data_0;
   assign if_z.wr_en_1   = if_a.wr_en_1;
   assign if_z.wr_addr_1 = if_a.wr_addr_1;
   assign if_z.wr_data_1 = if_a.wr_data_1;
   assign if_z.rsv_en    = if_a.rsv_en;
   assign if_z.rsv_addr  = if_a.rsv_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_a.rd_addr_a = '0; if_a.rd_addr_b = '0;
      if_a.wr_en_0 = 1'b0; if_a.wr_addr_0 = '0; if_a.wr_data_0 = '0;
      if_a.wr_en_1 = 1'b0; if_a.wr_addr_1 = '0; if_a.wr_data_1 = '0;
      if_a.rsv_en = 1'b0;  if_a.rsv_addr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      if_w.rd_addr_a = '0; if_w.rd_addr_b = '0;
      if_w.wr_en_0 = 1'b0; if_w.wr_addr_0 = '0; if_w.wr_data_0 = '0;
      if_w.wr_en_1 = 1'b0; if_w.wr_addr_1 = '0; if_w.wr_data_1 = '0;
      if_w.rsv_en = 1'b0;  if_w.rsv_addr = '0;
      #1;
      n_cmp++; if (if_a.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data_a got %h want 0000", if_a.rd_data_a); end
      n_cmp++; if (if_a.rd_data_b !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data_b got %h want 0000", if_a.rd_data_b); end
      n_cmp++; if ({if_a.rd_busy_a, if_a.rd_busy_b} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy got %b want 00", {if_a.rd_busy_a, if_a.rd_busy_b}); end
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_busy_vec got %h want 00", if_a.busy_vec); end
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd3; if_a.wr_data_0 = 16'h1234;
      if_a.rsv_en = 1'b1;  if_a.rsv_addr = 3'd5;
      if_a.rd_addr_a = 3'd3;
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'h1234) begin n_fail++; $display("FAIL mid_pre_rd got %h want 1234", if_a.rd_data_a); end
      n_cmp++; if (if_a.busy_vec !== 8'h20) begin n_fail++; $display("FAIL mid_pre_busy got %h want 20", if_a.busy_vec); end
      // assert reset away from an edge, with a write still being offered
      if_a.wr_data_0 = 16'h5555;
      reset = 1'b1;
      #1;
      n_cmp++; if (if_a.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL mid_async_rd got %h want 0000", if_a.rd_data_a); end
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL mid_async_busy got %h want 00", if_a.busy_vec); end
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL mid_reset_dominates got %h want 0000", if_a.rd_data_a); end
      reset = 1'b0;
      idle();
      if_a.rd_addr_a = 3'd3;
      if_a.rd_addr_b = 3'd5;
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL mid_post_r3 got %h want 0000", if_a.rd_data_a); end
      n_cmp++; if (if_a.rd_busy_b !== 1'b0) begin n_fail++; $display("FAIL mid_post_busy_r5 got %b want 0", if_a.rd_busy_b); end
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL mid_post_busy_vec got %h want 00", if_a.busy_vec); end
   endtask

   task automatic test_bypass();
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd2; if_a.wr_data_0 = 16'hBEEF;
      if_a.rd_addr_a = 3'd2;
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_data got %h want beef", if_a.rd_data_a); end
      n_cmp++; if (if_a.rd_busy_a !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b want 0", if_a.rd_busy_a); end
   endtask

   task automatic test_collision();
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd4; if_a.wr_data_0 = 16'h1111;
      if_a.wr_en_1 = 1'b1; if_a.wr_addr_1 = 3'd4; if_a.wr_data_1 = 16'h2222;
      if_a.rd_addr_b = 3'd4;
      step();
      n_cmp++; if (if_a.rd_data_b !== 16'h2222) begin n_fail++; $display("FAIL collide_bypass got %h want 2222", if_a.rd_data_b); end
      idle();
      if_a.rd_addr_a = 3'd4;
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'h2222) begin n_fail++; $display("FAIL collide_stored got %h want 2222", if_a.rd_data_a); end
   endtask

   task automatic test_scoreboard();
      idle();
      if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd6;
      if_a.rd_addr_a = 3'd6;
      step();
      n_cmp++; if (if_a.busy_vec !== 8'h40) begin n_fail++; $display("FAIL sb_set_vec got %h want 40", if_a.busy_vec); end
      n_cmp++; if (if_a.rd_busy_a !== 1'b1) begin n_fail++; $display("FAIL sb_set_rd_busy got %b want 1", if_a.rd_busy_a); end
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd6; if_a.wr_data_0 = 16'h6666;
      if_a.rd_addr_a = 3'd6;
      step();
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL sb_clear_vec got %h want 00", if_a.busy_vec); end
      n_cmp++; if (if_a.rd_busy_a !== 1'b0) begin n_fail++; $display("FAIL sb_clear_rd_busy got %b want 0", if_a.rd_busy_a); end
      n_cmp++; if (if_a.rd_data_a !== 16'h6666) begin n_fail++; $display("FAIL sb_clear_data got %h want 6666", if_a.rd_data_a); end
      idle();
      if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd6;
      if_a.wr_en_1 = 1'b1; if_a.wr_addr_1 = 3'd6; if_a.wr_data_1 = 16'h7777;
      if_a.rd_addr_b = 3'd6;
      step();
      n_cmp++; if (if_a.busy_vec !== 8'h40) begin n_fail++; $display("FAIL sb_rsv_wins_vec got %h want 40", if_a.busy_vec); end
      n_cmp++; if (if_a.rd_busy_b !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_wins_rd_busy got %b want 1", if_a.rd_busy_b); end
      n_cmp++; if (if_a.rd_data_b !== 16'h7777) begin n_fail++; $display("FAIL sb_rsv_wins_data got %h want 7777", if_a.rd_data_b); end
      // write to a non-busy register, release r6 via port 1, reserve r7
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd1; if_a.wr_data_0 = 16'h0101;
      if_a.wr_en_1 = 1'b1; if_a.wr_addr_1 = 3'd6; if_a.wr_data_1 = 16'h0606;
      if_a.rsv_en = 1'b1;  if_a.rsv_addr = 3'd7;
      if_a.rd_addr_a = 3'd1; if_a.rd_addr_b = 3'd7;
      step();
      n_cmp++; if (if_a.busy_vec !== 8'h80) begin n_fail++; $display("FAIL sb_move_vec got %h want 80", if_a.busy_vec); end
      n_cmp++; if ({if_a.rd_busy_a, if_a.rd_busy_b} !== 2'b01) begin n_fail++; $display("FAIL sb_move_rd_busy got %b want 01", {if_a.rd_busy_a, if_a.rd_busy_b}); end
      n_cmp++; if (if_a.rd_data_a !== 16'h0101) begin n_fail++; $display("FAIL sb_nonbusy_write got %h want 0101", if_a.rd_data_a); end
   endtask

   task automatic test_dual_write();
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd1; if_a.wr_data_0 = 16'hAAAA;
      if_a.wr_en_1 = 1'b1; if_a.wr_addr_1 = 3'd7; if_a.wr_data_1 = 16'h5555;
      step();
      idle();
      if_a.rd_addr_a = 3'd1; if_a.rd_addr_b = 3'd7;
      step();
      n_cmp++; if (if_a.rd_data_a !== 16'hAAAA) begin n_fail++; $display("FAIL dual_port0 got %h want aaaa", if_a.rd_data_a); end
      n_cmp++; if (if_a.rd_data_b !== 16'h5555) begin n_fail++; $display("FAIL dual_port1 got %h want 5555", if_a.rd_data_b); end
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL dual_busy_vec got %h want 00", if_a.busy_vec); end
   endtask

   task automatic test_zero_reg();
      idle();
      if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd0; if_a.wr_data_0 = 16'hFFFF;
      if_a.rsv_en = 1'b1;  if_a.rsv_addr = 3'd0;
      if_a.rd_addr_a = 3'd0;
      step();
      n_cmp++; if (if_z.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL zr1_data got %h want 0000", if_z.rd_data_a); end
      n_cmp++; if (if_z.busy_vec !== 8'h00) begin n_fail++; $display("FAIL zr1_busy_vec got %h want 00", if_z.busy_vec); end
      n_cmp++; if (if_z.rd_busy_a !== 1'b0) begin n_fail++; $display("FAIL zr1_rd_busy got %b want 0", if_z.rd_busy_a); end
      n_cmp++; if (if_a.rd_data_a !== 16'hFFFF) begin n_fail++; $display("FAIL zr0_data got %h want ffff", if_a.rd_data_a); end
      n_cmp++; if (if_a.busy_vec !== 8'h01) begin n_fail++; $display("FAIL zr0_busy_vec got %h want 01", if_a.busy_vec); end
      idle();
      if_a.wr_en_1 = 1'b1; if_a.wr_addr_1 = 3'd0; if_a.wr_data_1 = 16'h1357;
      if_a.rd_addr_b = 3'd0;
      step();
      n_cmp++; if (if_z.rd_data_b !== 16'h0) begin n_fail++; $display("FAIL zr1_port1_data got %h want 0000", if_z.rd_data_b); end
      n_cmp++; if (if_a.rd_data_b !== 16'h1357) begin n_fail++; $display("FAIL zr0_port1_data got %h want 1357", if_a.rd_data_b); end
      n_cmp++; if (if_a.busy_vec !== 8'h00) begin n_fail++; $display("FAIL zr0_release got %h want 00", if_a.busy_vec); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [3];
      vals[0] = 16'h0001; vals[1] = 16'h00F2; vals[2] = 16'hC003;
      for (int k = 0; k < 3; k++) begin
         idle();
         if_a.wr_en_0 = 1'b1; if_a.wr_addr_0 = 3'd5; if_a.wr_data_0 = vals[k];
         if_a.rd_addr_a = 3'd5;
         step();
         n_cmp++; if (if_a.rd_data_a !== vals[k]) begin n_fail++; $display("FAIL b2b_%0d got %h want %h", k, if_a.rd_data_a, vals[k]); end
      end
      idle();
   endtask

   function automatic logic [4:0] rnd_addr();
      // bias towards a few registers so collisions and reserve/release overlaps happen often
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 5));
   endfunction

   task automatic test_random_wide();
      logic [31:0] ref_mem [32];
      logic [31:0] ref_busy;
      logic [31:0] exp_a, exp_b;
      logic        exp_ba, exp_bb;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_busy = '0;
      for (int c = 0; c < 10000; c++) begin
         if_w.rd_addr_a = rnd_addr(); if_w.rd_addr_b = rnd_addr();
         if_w.wr_en_0 = ($urandom_range(0, 1) == 1); if_w.wr_addr_0 = rnd_addr(); if_w.wr_data_0 = $urandom;
         if_w.wr_en_1 = ($urandom_range(0, 1) == 1); if_w.wr_addr_1 = rnd_addr(); if_w.wr_data_1 = $urandom;
         if_w.rsv_en  = ($urandom_range(0, 2) == 0); if_w.rsv_addr  = rnd_addr();
         // reference: port 0 then port 1 (younger wins), releases then reservation
         if (if_w.wr_en_0) begin ref_mem[if_w.wr_addr_0] = if_w.wr_data_0; ref_busy[if_w.wr_addr_0] = 1'b0; end
         if (if_w.wr_en_1) begin ref_mem[if_w.wr_addr_1] = if_w.wr_data_1; ref_busy[if_w.wr_addr_1] = 1'b0; end
         if (if_w.rsv_en) ref_busy[if_w.rsv_addr] = 1'b1;
         exp_a = ref_mem[if_w.rd_addr_a]; exp_b = ref_mem[if_w.rd_addr_b];
         exp_ba = ref_busy[if_w.rd_addr_a]; exp_bb = ref_busy[if_w.rd_addr_b];
         step();
         n_cmp++; if ({if_w.rd_data_a, if_w.rd_data_b} !== {exp_a, exp_b}) begin n_fail++; $display("FAIL wide_data cyc %0d got %h/%h want %h/%h", c, if_w.rd_data_a, if_w.rd_data_b, exp_a, exp_b); end
         n_cmp++; if ({if_w.rd_busy_a, if_w.rd_busy_b} !== {exp_ba, exp_bb}) begin n_fail++; $display("FAIL wide_rd_busy cyc %0d got %b%b want %b%b", c, if_w.rd_busy_a, if_w.rd_busy_b, exp_ba, exp_bb); end
         n_cmp++; if (if_w.busy_vec !== ref_busy) begin n_fail++; $display("FAIL wide_busy_vec cyc %0d got %h want %h", c, if_w.busy_vec, ref_busy); end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_reset_mid();
      test_bypass();
      test_collision();
      test_scoreboard();
      test_dual_write();
      test_zero_reg();
      test_back_to_back();
      test_random_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
